// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths and word layout for the ecc_encoder -> ecc_word_fifo ->
// ecc_decoder path.
//   ECC_DATA_W / ECC_CODE_W : payload and check-code widths
//   ecc_word_t              : {code, data}, with the code in the MSBs
//   ecc_word_w()            : total stored word width
package ecc_pkg;

  localparam int ECC_DATA_W = 26;
  localparam int ECC_CODE_W = 5;

  typedef struct packed {
    logic [ECC_CODE_W-1:0] code;
    logic [ECC_DATA_W-1:0] data;
  } ecc_word_t;

  function automatic int ecc_word_w();
    return ECC_DATA_W + ECC_CODE_W;
  endfunction

endpackage

// File: rtl/ecc_sram_1r1w.sv
// ecc_sram_1r1w: DEPTH x W storage array with one write port and one read port.
// The read data is registered: it appears one cycle after re is sampled high and
// then holds until the next read. The array and the read register are not reset.
// Ports:
//   clk          rising-edge clock
//   we/waddr/wdata  write port
//   re/raddr     read request
//   rdata        registered read data
module ecc_sram_1r1w
  import ecc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = ecc_word_w()
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ecc_word_fifo.sv
// ecc_word_fifo: buffers {code,data} codewords between ecc_encoder and
// ecc_decoder and replays them in order, unmodified.
// Optional feature macro: ECC_ERR_INJECT_EN adds inj_mask; the stored word is
// then {in_code,in_data} ^ inj_mask.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   in_data/in_code/in_vld  write side; a write while full is dropped
//   in_rdy                !full (no dependency on out_rdy)
//   out_data/out_code/out_vld/out_rdy  read side
//   count                 occupancy including the output word
//   overflow              sticky: a write was attempted while full
// Handshake: a word moves on a rising edge where its valid and ready are both 1.
// out_* are held stable while out_vld && !out_rdy; in_vld carries no
// back-pressure, so in_rdy is informational only.
module ecc_word_fifo
  import ecc_pkg::*;
#(
  parameter int DATA_W = ECC_DATA_W,
  parameter int CODE_W = ECC_CODE_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CODE_W-1:0]        in_code,
  input  logic                     in_vld,
`ifdef ECC_ERR_INJECT_EN
  input  logic [DATA_W+CODE_W-1:0] inj_mask,
`endif
  output logic                     in_rdy,
  output logic [DATA_W-1:0]        out_data,
  output logic [CODE_W-1:0]        out_code,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = DATA_W + CODE_W;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] mem_cnt, count_nxt;
  logic [W-1:0]  wdata, mem_q, out_q;
  logic          src_mem;  // 1: output word is the sram read register
  logic          push, pop, out_free, byp, rd_en, wr_en;

`ifdef ECC_ERR_INJECT_EN
  assign wdata = {in_code, in_data} ^ inj_mask;
`else
  assign wdata = {in_code, in_data};
`endif

  assign in_rdy   = (count != CW'(DEPTH));
  assign push     = in_vld && in_rdy;
  assign pop      = out_vld && out_rdy;
  assign out_free = !out_vld || pop;
  // Words still in the array, i.e. not yet in the output slot.
  assign mem_cnt  = count - CW'(out_vld);
  // The output slot is refilled from the array whenever it frees up. When the
  // array is empty and the current output word is consumed while a new word
  // arrives, the new word goes straight to the output so out_vld stays high.
  assign rd_en    = out_free && (mem_cnt != '0);
  assign byp      = push && pop && (mem_cnt == '0);
  // rd_en implies mem_cnt != 0, and mem_cnt == DEPTH implies full, so a read
  // and a write never target the same address on the same edge.
  assign wr_en    = push && !byp;

  assign {out_code, out_data} = src_mem ? mem_q : out_q;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  ecc_sram_1r1w #(.DEPTH(DEPTH), .W(W)) u_sram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (mem_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      out_vld  <= 1'b0;
      src_mem  <= 1'b0;
      out_q    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (in_vld && !in_rdy) overflow <= 1'b1;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + AW'(1);
        out_vld <= 1'b1;
        src_mem <= 1'b1;
      end else if (byp) begin
        out_q   <= wdata;
        out_vld <= 1'b1;
        src_mem <= 1'b0;
      end else if (pop) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ecc_word_fifo.sv
// tb_ecc_word_fifo: directed and randomised checks of ecc_word_fifo against a
// queue model of the stored words.
module tb_ecc_word_fifo;
  import ecc_pkg::*;

  localparam int DATA_W = 26;
  localparam int CODE_W = 5;
  localparam int DEPTH  = 16;
  localparam int W      = DATA_W + CODE_W;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic [CODE_W-1:0] in_code;
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic [CODE_W-1:0] out_code;
  logic              out_vld;
  logic              out_rdy;
  logic [4:0]        count;
  logic              overflow;
`ifdef ECC_ERR_INJECT_EN
  logic [W-1:0]      inj_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ovf;
  int           n_pops;

  ecc_word_fifo #(.DATA_W(DATA_W), .CODE_W(CODE_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_code  (in_code),
    .in_vld   (in_vld),
`ifdef ECC_ERR_INJECT_EN
    .inj_mask (inj_mask),
`endif
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_code (out_code),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .count    (count),
    .overflow (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CODE_W-1:0] code_of(input logic [DATA_W-1:0] d);
    return d[CODE_W-1:0] ^ 5'h0B;
  endfunction

  // driver tasks
  task automatic drive(input logic vld, input logic [DATA_W-1:0] d, input logic rdy);
    in_vld  = vld;
    in_data = d;
    in_code = code_of(d);
    out_rdy = rdy;
  endtask

  task automatic do_reset();
    in_vld  = 1'b0;
    in_data = '0;
    in_code = '0;
    out_rdy = 1'b0;
`ifdef ECC_ERR_INJECT_EN
    inj_mask = '0;
`endif
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    reset = 1'b1;
  endtask

  // One clock edge with the scoreboard updated around it.
  task automatic tick();
    logic         pop, acc, stall;
    logic [W-1:0] got, wr_word;
    pop   = out_vld && out_rdy;
    acc   = in_vld && (exp_q.size() < DEPTH);
    stall = out_vld && !out_rdy;
    got   = {out_code, out_data};
    wr_word = {in_code, in_data};
`ifdef ECC_ERR_INJECT_EN
    wr_word = wr_word ^ inj_mask;
`endif
    if (in_vld && exp_q.size() == DEPTH) exp_ovf = 1'b1;
    if (pop) begin
      n_pops++;
      if (exp_q.size() == 0) check("pop_when_model_empty", 1, 0);
      else begin
        check("order", got, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(wr_word);
    check("count", count, exp_q.size());
    check("in_rdy", in_rdy, exp_q.size() != DEPTH);
    check("overflow", overflow, exp_ovf);
    if (out_vld) check("vld_with_model_empty", exp_q.size() == 0, 0);
    if (stall) check("stall_hold", {out_code, out_data}, got);
  endtask

  task automatic drain();
    int k;
    drive(1'b0, '0, 1'b1);
    k = 0;
    while ((exp_q.size() != 0 || count != 0) && k < 40) begin
      tick();
      k++;
    end
    check("drain_timeout", k >= 40, 0);
  endtask

  initial begin
    int peak;
    do_reset();

    // reset state
    check("rst_count", count, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_code", out_code, 0);

    // 1: five words back-to-back, first output one cycle after acceptance
    drive(1'b1, 26'd1, 1'b1);
    tick();
    check("t1_lat_t", out_vld, 0);
    drive(1'b1, 26'd2, 1'b1);
    tick();
    check("t1_lat_t1", out_vld, 1);
    check("t1_first_data", out_data, 1);
    peak = count;
    for (int d = 3; d <= 5; d++) begin
      drive(1'b1, DATA_W'(d), 1'b1);
      tick();
      if (count > peak) peak = count;
    end
    drive(1'b0, '0, 1'b1);
    repeat (4) tick();
    check("t1_peak", peak, 2);
    check("t1_empty", count, 0);

    // 2: fill to DEPTH with out_rdy low, then an extra word is dropped
    n_pops = 0;
    for (int d = 0; d < DEPTH; d++) begin
      drive(1'b1, DATA_W'(d), 1'b0);
      tick();
    end
    check("t2_full_count", count, 16);
    check("t2_full_rdy", in_rdy, 0);
    check("t2_no_ovf", overflow, 0);
    check("t2_head", out_data, 0);
    drive(1'b1, 26'h3FF, 1'b0);
    tick();
    check("t2_ovf", overflow, 1);
    check("t2_count_kept", count, 16);

    // 3: full, write and pop on the same edge -> pop only
    drive(1'b1, 26'h3FE, 1'b1);
    tick();
    check("t3_count", count, 15);
    check("t3_ovf", overflow, 1);
    drain();
    check("t2_pops", n_pops, 16);

    // 4: sustained one word per cycle
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1);
      tick();
      if (i >= 1) check("t4_gap", out_vld, 1);
      check("t4_count_le2", count <= 2, 1);
    end
    drain();

    // 5: random valid/ready
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    drain();

    // 6: reset with words stored drops out_vld and count at once
    do_reset();
    for (int d = 0; d < 7; d++) begin
      drive(1'b1, DATA_W'(d + 100), 1'b0);
      tick();
    end
    check("t6_seven", count, 7);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_vld", out_vld, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_ovf", overflow, 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 26'hA, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    tick();
    check("t6_after_vld", out_vld, 1);
    check("t6_after_data", out_data, 26'hA);
    drain();

`ifdef ECC_ERR_INJECT_EN
    drive(1'b1, 26'h0, 1'b0);
    inj_mask = W'(1) << 3;
    tick();
    inj_mask = '0;
    drive(1'b0, '0, 1'b0);
    tick();
    check("inj_data", out_data, 26'h8);
    check("inj_code", out_code, 5'h0B);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
